// File: rtl/parking_pkg.sv
// Shared parking-lot constants and the exit-gate state encoding.
// The entry controller imports the same package so both gates agree on capacity.
package parking_pkg;

   localparam int unsigned DEF_CAPACITY  = 8;
   localparam int unsigned DEF_CNT_W     = 4;
   localparam int unsigned DEF_TIMEOUT   = 16;
   localparam int unsigned DEF_ALARM_MIN = 4;

   typedef logic [1:0] exit_state_t;

   localparam exit_state_t StIdle    = 2'd0;
   localparam exit_state_t StOpen    = 2'd1;
   localparam exit_state_t StPassing = 2'd2;
   localparam exit_state_t StAlarm   = 2'd3;

endpackage

// File: rtl/occupancy_counter.sv
// Saturating up/down car counter with registered full/empty flags.
// Simultaneous inc and dec cancel, so the count stays put.
module occupancy_counter #(
   parameter int unsigned CAPACITY = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam logic [CNT_W-1:0] CapC = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] OneC = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_d;
   logic             r_full;
   logic             r_empty;

   always_comb begin
      w_count_d = r_count;
      if (i_inc && !i_dec) begin
         if (r_count != CapC) w_count_d = r_count + OneC;
      end else if (i_dec && !i_inc) begin
         if (r_count != '0) w_count_d = r_count - OneC;
      end
   end

   // Flags come from the next count so they line up with o_count every cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_count <= w_count_d;
         r_full  <= (w_count_d == CapC);
         r_empty <= (w_count_d == '0);
      end
   end

   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/parking_exit_controller.sv
// Exit barrier controller: opens for a leaving car, confirms it has passed,
// and owns the shared occupancy count fed by the entry gate's car_entered pulse.
module parking_exit_controller
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY  = DEF_CAPACITY,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter int unsigned ALARM_MIN = DEF_ALARM_MIN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             insensor,
   input  logic             outsensor,
   input  logic             car_entered,
   output logic             GREENLED,
   output logic             REDLED,
   output logic             barrier_open,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty
);

   localparam int unsigned TmrMax = (TIMEOUT > ALARM_MIN) ? TIMEOUT : ALARM_MIN;
   localparam int unsigned TMR_W  = $clog2(TmrMax + 1);

   localparam logic [TMR_W-1:0] TimeoutLastC = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] AlarmMinC    = TMR_W'(ALARM_MIN);
   localparam logic [TMR_W-1:0] AlarmLastC   = TMR_W'(ALARM_MIN - 1);
   localparam logic [TMR_W-1:0] TmrOneC      = TMR_W'(1);

   exit_state_t      r_state;
   exit_state_t      w_state_d;
   logic [TMR_W-1:0] r_timer;
   logic [TMR_W-1:0] w_timer_d;
   logic             w_dec;
   logic             w_sensors_clear;
   logic             r_green;
   logic             r_red;
   logic             r_barrier;

   assign w_sensors_clear = !insensor && !outsensor;

   always_comb begin
      w_state_d = r_state;
      w_timer_d = r_timer;
      w_dec     = 1'b0;
      case (r_state)
         StIdle: begin
            w_timer_d = '0;
            // An exit request with nobody inside is a phantom exit.
            if (insensor) w_state_d = empty ? StAlarm : StOpen;
         end
         StOpen: begin
            if (outsensor) begin
               w_state_d = StPassing;
               w_timer_d = '0;
            end else if (r_timer == TimeoutLastC) begin
               w_state_d = StAlarm;
               w_timer_d = '0;
            end else begin
               w_timer_d = r_timer + TmrOneC;
            end
         end
         StPassing: begin
            w_timer_d = '0;
            if (w_sensors_clear) begin
               w_state_d = StIdle;
               w_dec     = 1'b1;
            end
         end
         StAlarm: begin
            if (r_timer != AlarmMinC) w_timer_d = r_timer + TmrOneC;
            if (r_timer >= AlarmLastC && w_sensors_clear) begin
               w_state_d = StIdle;
               w_timer_d = '0;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_timer_d = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_timer   <= '0;
         r_green   <= 1'b0;
         r_red     <= 1'b0;
         r_barrier <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_timer   <= w_timer_d;
         r_green   <= (w_state_d == StOpen) || (w_state_d == StPassing);
         r_red     <= (w_state_d == StAlarm);
         r_barrier <= (w_state_d == StOpen) || (w_state_d == StPassing);
      end
   end

   occupancy_counter #(
      .CAPACITY (CAPACITY),
      .CNT_W    (CNT_W)
   ) u_occ (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_inc   (car_entered),
      .i_dec   (w_dec),
      .o_count (occupancy),
      .o_full  (full),
      .o_empty (empty)
   );

   assign GREENLED     = r_green;
   assign REDLED       = r_red;
   assign barrier_open = r_barrier;

endmodule
